// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
// Holds the run-state enum, the active-low 7-segment table and a preset clamp helper.
package bcd_timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Active-low {dp,g,f,e,d,c,b,a}; dp kept off (1) in every code.
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Index 0 is the rightmost entry: digit n lives at SEG_TABLE[n].
   localparam logic [9:0][7:0] SEG_TABLE = {
      8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
      8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   // Switch values above 9 saturate to 9 so the tens digit stays valid BCD.
   function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
      logic [3:0] r;
      if (v > 4'd9) begin
         r = 4'd9;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment code.
// Non-BCD inputs (10..15) produce a blank display.
module seg7_decoder
   import bcd_timer_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [7:0] seg
);

   // Table lookup with blank fallback for illegal digits.
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_TABLE[4'd0];
         4'd1:    seg = SEG_TABLE[4'd1];
         4'd2:    seg = SEG_TABLE[4'd2];
         4'd3:    seg = SEG_TABLE[4'd3];
         4'd4:    seg = SEG_TABLE[4'd4];
         4'd5:    seg = SEG_TABLE[4'd5];
         4'd6:    seg = SEG_TABLE[4'd6];
         4'd7:    seg = SEG_TABLE[4'd7];
         4'd8:    seg = SEG_TABLE[4'd8];
         4'd9:    seg = SEG_TABLE[4'd9];
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Two-digit BCD countdown timer controller with tens/units 7-segment outputs.
// A single start button cycles IDLE -> RUN <-> PAUSE -> DONE -> IDLE.
// Optional feature macro: BLINK_ON_DONE_EN (blink "00" while in DONE).
module bcd_timer_ctrl
   import bcd_timer_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000
)
(
   input  logic       clk_clk,
   input  logic       reset_reset,
   input  logic [3:0] chave,
   input  logic       start,
   output logic [7:0] dezena,
   output logic [7:0] unidade,
   output logic       done,
   output logic       running
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
   localparam logic [PW-1:0] TICK_MAX   = PW'(TICK_DIV - 1);
`ifdef BLINK_ON_DONE_EN
   localparam logic [PW-1:0] BLINK_HALF = PW'(TICK_DIV / 2);
`endif

   logic          start_meta_r;
   logic          start_sync_r;
   logic          start_prev_r;
   logic          start_pulse_s;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [3:0]    tens_r;
   logic [3:0]    units_r;
   logic [3:0]    tens_nxt_s;
   logic [3:0]    units_nxt_s;
   logic [PW-1:0] presc_r;
   logic [PW-1:0] presc_nxt_s;
   logic          tick_s;

   logic [3:0]    preset_s;
   logic [3:0]    dec_tens_s;
   logic [3:0]    dec_units_s;
   logic          dec_zero_s;

   logic [3:0]    disp_tens_s;
   logic [3:0]    disp_units_s;
   logic [7:0]    tens_code_s;
   logic [7:0]    units_code_s;
   logic          blank_s;

   logic [7:0]    dezena_r;
   logic [7:0]    unidade_r;
   logic          done_r;
   logic          running_r;

   assign preset_s      = clamp_bcd(chave);
   assign tick_s        = (presc_r == TICK_MAX);
   assign start_pulse_s = start_sync_r & ~start_prev_r;

   // Two-flop synchroniser for the raw button, plus the previous-level register for edge detection.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         start_meta_r <= 1'b0;
         start_sync_r <= 1'b0;
         start_prev_r <= 1'b0;
      end else begin
         start_meta_r <= start;
         start_sync_r <= start_meta_r;
         start_prev_r <= start_sync_r;
      end
   end

   // One-step BCD decrement, saturating at 00 so the count can never wrap.
   always_comb begin
      dec_tens_s  = tens_r;
      dec_units_s = units_r;
      if (units_r != 4'd0) begin
         dec_units_s = units_r - 4'd1;
      end else if (tens_r != 4'd0) begin
         dec_units_s = 4'd9;
         dec_tens_s  = tens_r - 4'd1;
      end else begin
         dec_units_s = 4'd0;
         dec_tens_s  = 4'd0;
      end
      dec_zero_s = (dec_tens_s == 4'd0) && (dec_units_s == 4'd0);
   end

   // State, count and prescaler registers.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_r <= IDLE;
         tens_r  <= 4'd0;
         units_r <= 4'd0;
         presc_r <= PRESC_ZERO;
      end else begin
         state_r <= state_nxt_s;
         tens_r  <= tens_nxt_s;
         units_r <= units_nxt_s;
         presc_r <= presc_nxt_s;
      end
   end

   // Next-state logic; a tick coinciding with a button press decrements before deciding the state.
   always_comb begin
      state_nxt_s = state_r;
      tens_nxt_s  = tens_r;
      units_nxt_s = units_r;
      presc_nxt_s = presc_r;
      case (state_r)
         IDLE: begin
            presc_nxt_s = PRESC_ZERO;
            if (start_pulse_s) begin
               tens_nxt_s  = preset_s;
               units_nxt_s = 4'd0;
               if (preset_s == 4'd0) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = RUN;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (tick_s) begin
               presc_nxt_s = PRESC_ZERO;
               tens_nxt_s  = dec_tens_s;
               units_nxt_s = dec_units_s;
               if (dec_zero_s) begin
                  state_nxt_s = DONE;
               end else if (start_pulse_s) begin
                  state_nxt_s = PAUSE;
               end else begin
                  state_nxt_s = RUN;
               end
            end else begin
               presc_nxt_s = presc_r + PRESC_ONE;
               if (start_pulse_s) begin
                  state_nxt_s = PAUSE;
               end else begin
                  state_nxt_s = RUN;
               end
            end
         end
         PAUSE: begin
            if (start_pulse_s) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = PAUSE;
            end
         end
         DONE: begin
            tens_nxt_s  = 4'd0;
            units_nxt_s = 4'd0;
`ifdef BLINK_ON_DONE_EN
            if (tick_s) begin
               presc_nxt_s = PRESC_ZERO;
            end else begin
               presc_nxt_s = presc_r + PRESC_ONE;
            end
`else
            presc_nxt_s = PRESC_ZERO;
`endif
            if (start_pulse_s) begin
               state_nxt_s = IDLE;
               presc_nxt_s = PRESC_ZERO;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            tens_nxt_s  = 4'd0;
            units_nxt_s = 4'd0;
            presc_nxt_s = PRESC_ZERO;
         end
      endcase
   end

   // Digit selection: IDLE previews the preset, DONE forces 00, otherwise the live count.
   always_comb begin
      disp_tens_s  = 4'd0;
      disp_units_s = 4'd0;
      case (state_r)
         IDLE: begin
            disp_tens_s  = preset_s;
            disp_units_s = 4'd0;
         end
         RUN, PAUSE: begin
            disp_tens_s  = tens_r;
            disp_units_s = units_r;
         end
         DONE: begin
            disp_tens_s  = 4'd0;
            disp_units_s = 4'd0;
         end
         default: begin
            disp_tens_s  = 4'd0;
            disp_units_s = 4'd0;
         end
      endcase
   end

   // Blank phase of the DONE blink (second half of each prescaler period).
   always_comb begin
`ifdef BLINK_ON_DONE_EN
      if ((state_r == DONE) && (presc_r >= BLINK_HALF)) begin
         blank_s = 1'b1;
      end else begin
         blank_s = 1'b0;
      end
`else
      blank_s = 1'b0;
`endif
   end

   seg7_decoder u_tens_dec (
      .bcd (disp_tens_s),
      .seg (tens_code_s)
   );

   seg7_decoder u_units_dec (
      .bcd (disp_units_s),
      .seg (units_code_s)
   );

   // Output registers: displays and status flags lag the state/count by one cycle.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         dezena_r  <= SEG_TABLE[4'd0];
         unidade_r <= SEG_TABLE[4'd0];
         done_r    <= 1'b0;
         running_r <= 1'b0;
      end else begin
         dezena_r  <= blank_s ? SEG_BLANK : tens_code_s;
         unidade_r <= blank_s ? SEG_BLANK : units_code_s;
         done_r    <= (state_r == DONE);
         running_r <= (state_r == RUN);
      end
   end

   assign dezena  = dezena_r;
   assign unidade = unidade_r;
   assign done    = done_r;
   assign running = running_r;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl with TICK_DIV=4.
// An integer-count reference model predicts all outputs every cycle; directed
// literal checks pin the model. Build with BLINK_ON_DONE_EN to test the blink variant.
module tb_bcd_timer_ctrl;

   localparam int TD = 4;

   logic       clk_clk     = 1'b0;
   logic       reset_reset = 1'b1;
   logic [3:0] chave       = 4'd0;
   logic       start       = 1'b0;
   logic [7:0] dezena;
   logic [7:0] unidade;
   logic       done;
   logic       running;

   bcd_timer_ctrl #(.TICK_DIV(TD)) dut (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .chave       (chave),
      .start       (start),
      .dezena      (dezena),
      .unidade     (unidade),
      .done        (done),
      .running     (running)
   );

   // Free-running 10 ns clock.
   always #5 clk_clk = ~clk_clk;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   logic [7:0] seg_tbl [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: 0=idle 1=run 2=pause 3=done, count held as a plain integer 0..99.
   int  m_st  = 0;
   int  m_cnt = 0;
   int  m_ph  = 0;
   int  m_dph = 0;
   bit  q0 = 1'b0, q1 = 1'b0, q2 = 1'b0;
   bit  m_pulse;
   int  m_pre, m_t, m_u;
   logic [7:0] e_dez  = 8'hC0;
   logic [7:0] e_uni  = 8'hC0;
   logic       e_done = 1'b0;
   logic       e_run  = 1'b0;

   // Model step: outputs come from the pre-edge state, then the state advances.
   initial forever begin
      @(posedge clk_clk or posedge reset_reset);
      if (reset_reset) begin
         m_st = 0; m_cnt = 0; m_ph = 0; m_dph = 0;
         q0 = 1'b0; q1 = 1'b0; q2 = 1'b0;
         e_dez = 8'hC0; e_uni = 8'hC0; e_done = 1'b0; e_run = 1'b0;
      end else begin
         m_pulse = q1 && !q2;
         m_pre = (chave > 4'd9) ? 9 : int'(chave);
         if (m_st == 0) begin
            m_t = m_pre; m_u = 0;
         end else if (m_st == 1 || m_st == 2) begin
            m_t = m_cnt / 10; m_u = m_cnt % 10;
         end else begin
            m_t = 0; m_u = 0;
         end
         e_dez  = seg_tbl[m_t];
         e_uni  = seg_tbl[m_u];
`ifdef BLINK_ON_DONE_EN
         if (m_st == 3 && m_dph >= TD / 2) begin
            e_dez = 8'hFF; e_uni = 8'hFF;
         end
`endif
         e_done = (m_st == 3);
         e_run  = (m_st == 1);
         case (m_st)
            0: if (m_pulse) begin
                  m_cnt = m_pre * 10;
                  m_ph  = 0;
                  m_dph = 0;
                  m_st  = (m_cnt == 0) ? 3 : 1;
               end
            1: begin
                  m_ph++;
                  if (m_ph == TD) begin
                     m_ph = 0;
                     m_cnt--;
                     if (m_cnt == 0) begin
                        m_st = 3; m_dph = 0;
                     end else if (m_pulse) begin
                        m_st = 2;
                     end
                  end else if (m_pulse) begin
                     m_st = 2;
                  end
               end
            2: if (m_pulse) m_st = 1;
            default: begin
                  m_dph = (m_dph + 1) % TD;
                  if (m_pulse) m_st = 0;
               end
         endcase
         q2 = q1; q1 = q0; q0 = start;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk_clk);
      if (check_en) begin
         chk("m_dezena",  {24'd0, dezena},  {24'd0, e_dez});
         chk("m_unidade", {24'd0, unidade}, {24'd0, e_uni});
         chk("m_done",    {31'd0, done},    {31'd0, e_done});
         chk("m_running", {31'd0, running}, {31'd0, e_run});
      end
   end

   task automatic press();
      start = 1'b1;
      repeat (4) @(negedge clk_clk);
      start = 1'b0;
   endtask

   int hold = 0;

   // Directed scenarios followed by randomized stimulus.
   initial begin
      repeat (3) @(negedge clk_clk);
      check_en = 1'b1;
      chk("rst_dezena",  {24'd0, dezena},  32'h0000_00C0);
      chk("rst_unidade", {24'd0, unidade}, 32'h0000_00C0);
      chk("rst_done",    {31'd0, done},    32'd0);
      chk("rst_running", {31'd0, running}, 32'd0);
      chave = 4'd5;
      reset_reset = 1'b0;
      @(negedge clk_clk);
      chk("preview5_dez", {24'd0, dezena},  32'h0000_0092);
      chk("preview5_uni", {24'd0, unidade}, 32'h0000_00C0);

      // Full countdown from 30.
      chave = 4'd3;
      press();
      chk("run30_running", {31'd0, running}, 32'd1);
      chk("run30_dez", {24'd0, dezena}, 32'h0000_00B0);
      repeat (4) @(negedge clk_clk);
      chk("show29_dez", {24'd0, dezena},  32'h0000_00A4);
      chk("show29_uni", {24'd0, unidade}, 32'h0000_0090);
      repeat (116) @(negedge clk_clk);
      chk("end_done",    {31'd0, done},    32'd1);
      chk("end_running", {31'd0, running}, 32'd0);
      chk("end_dez",     {24'd0, dezena},  32'h0000_00C0);
      chk("end_uni",     {24'd0, unidade}, 32'h0000_00C0);

      // DONE -> IDLE, then zero preset goes straight to DONE and back.
      press();
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_dez",  {24'd0, dezena}, 32'h0000_00B0);
      chave = 4'd0;
      repeat (2) @(negedge clk_clk);
      press();
      chk("zero_done", {31'd0, done}, 32'd1);
      chk("zero_dez",  {24'd0, dezena}, 32'h0000_00C0);
      repeat (2) @(negedge clk_clk);
      press();
      chk("zero_back_done", {31'd0, done}, 32'd0);
      chk("zero_back_run",  {31'd0, running}, 32'd0);

      // Pause at 17 and resume from the held prescaler.
      chave = 4'd2;
      repeat (2) @(negedge clk_clk);
      press();
      repeat (11) @(negedge clk_clk);
      press();
      chk("pause_running", {31'd0, running}, 32'd0);
      chk("pause_dez", {24'd0, dezena},  32'h0000_00F9);
      chk("pause_uni", {24'd0, unidade}, 32'h0000_00F8);
      repeat (100) @(negedge clk_clk);
      chk("held_dez", {24'd0, dezena},  32'h0000_00F9);
      chk("held_uni", {24'd0, unidade}, 32'h0000_00F8);
      press();
      chk("resume_running", {31'd0, running}, 32'd1);
      @(negedge clk_clk);
      chk("resume16_uni", {24'd0, unidade}, 32'h0000_0082);

      // chave ignored while running, then reset mid-RUN.
      chave = 4'hC;
      repeat (20) @(negedge clk_clk);
      #1 reset_reset = 1'b1;
      #1;
      chk("midrst_dez", {24'd0, dezena},  32'h0000_00C0);
      chk("midrst_uni", {24'd0, unidade}, 32'h0000_00C0);
      chk("midrst_run", {31'd0, running}, 32'd0);
      @(negedge clk_clk);
      #1 reset_reset = 1'b0;
      @(negedge clk_clk);
      chk("previewC_dez", {24'd0, dezena}, 32'h0000_0090);

      // Press aligned with the final tick at 01 must land in DONE.
      chave = 4'd1;
      repeat (2) @(negedge clk_clk);
      press();
      repeat (36) @(negedge clk_clk);
      press();
      chk("align_done", {31'd0, done}, 32'd1);
      chk("align_run",  {31'd0, running}, 32'd0);
      chk("align_dez",  {24'd0, dezena}, 32'h0000_00C0);
      repeat (2) @(negedge clk_clk);
`ifdef BLINK_ON_DONE_EN
      chk("blink_dez", {24'd0, dezena},  32'h0000_00FF);
      chk("blink_uni", {24'd0, unidade}, 32'h0000_00FF);
`else
      chk("steady_dez", {24'd0, dezena},  32'h0000_00C0);
      chk("steady_uni", {24'd0, unidade}, 32'h0000_00C0);
`endif

      // Randomized button levels, switch changes and rare resets.
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk_clk);
         #1;
         if (hold == 0) begin
            start = ~start;
            hold  = start ? $urandom_range(0, 5) : $urandom_range(0, 70);
         end else begin
            hold--;
         end
         if ($urandom_range(0, 20) == 0) chave = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 800) == 0) reset_reset = 1'b1;
         else reset_reset = 1'b0;
      end
      @(negedge clk_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
